// File: rtl/hb_pkg.sv
// Shared half-band definitions for the interpolating and decimating blocks.
// Holds the Q15 coefficient set of the 19-tap half-band filter, the tap and
// pair counts, the FSM state encoding and a pair-index to coefficient lookup.
package hb_pkg;

    localparam int COEF_W  = 16;
    localparam int N_TAPS  = 19;
    localparam int N_PAIRS = 5;

    // Even taps of the symmetric half-band; odd taps are zero except the centre.
    localparam logic signed [COEF_W-1:0] H0 = 16'sh0025;
    localparam logic signed [COEF_W-1:0] H2 = 16'shFF17;
    localparam logic signed [COEF_W-1:0] H4 = 16'sh035B;
    localparam logic signed [COEF_W-1:0] H6 = 16'shF606;
    localparam logic signed [COEF_W-1:0] H8 = 16'sh2765;
    localparam logic signed [COEF_W-1:0] H9 = 16'sh4000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAC    = 3'd1,
        EMIT_A = 3'd2,
        WAIT_B = 3'd3,
        EMIT_B = 3'd4
    } hb_state_t;

    // Pair k combines taps 2k and 18-2k, which share the coefficient h(2k).
    function automatic logic signed [COEF_W-1:0] hb_pair_coef(input logic [2:0] k);
        case (k)
            3'd0:    hb_pair_coef = H0;
            3'd1:    hb_pair_coef = H2;
            3'd2:    hb_pair_coef = H4;
            3'd3:    hb_pair_coef = H6;
            3'd4:    hb_pair_coef = H8;
            default: hb_pair_coef = '0;
        endcase
    endfunction

endpackage

// File: rtl/hb_serial_mac.sv
// Serial symmetric pre-add / multiply / accumulate datapath.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronously clears acc (start of a new output)
//   en       : adds (a + b) * coef into acc
//   a, b     : symmetric tap pair, DIN_W signed
//   coef     : shared pair coefficient, Q15 signed
//   acc      : DOUT_W signed accumulator, full precision, wraps only if undersized
module hb_serial_mac
    import hb_pkg::*;
#(
    parameter int DIN_W  = 47,
    parameter int DOUT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DIN_W-1:0]  a,
    input  logic signed [DIN_W-1:0]  b,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [DOUT_W-1:0] acc
);

    localparam int PRE_W  = DIN_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;

    logic signed [PRE_W-1:0]  pre_p0;
    logic signed [PROD_W-1:0] prod_p0;

    // stage 0: pre-add and multiply, combinational
    always_comb begin
        pre_p0  = PRE_W'(a) + PRE_W'(b);
        prod_p0 = PROD_W'(pre_p0) * PROD_W'(coef);
    end

    // stage 1: accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + DOUT_W'(prod_p0);
        end
    end

endmodule

// File: rtl/half_band_interp.sv
// 2x half-band interpolator. Each accepted input produces two outputs:
// the even (FIR) phase 6 cycles after nd, computed on one serial multiplier,
// and the odd (centre-tap) phase HALF_PERIOD cycles after nd.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   nd, din   : new-data strobe and signed input sample
//   dout      : signed interpolated sample, held between pulses
//   dout_vld  : one-cycle pulse per new dout
//   dout_ph   : 0 = even/FIR phase, 1 = odd/centre phase
//   ovf       : sticky, set when an nd arrives while busy
module half_band_interp
    import hb_pkg::*;
#(
    parameter int HALF_PERIOD = 128,
    parameter int DIN_W       = 47,
    parameter int DOUT_W      = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nd,
    input  logic signed [DIN_W-1:0]  din,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     dout_vld,
    output logic                     dout_ph,
    output logic                     ovf
);

    localparam int CNT_W  = $clog2(HALF_PERIOD) + 1;
    localparam int PROD_W = DIN_W + COEF_W;

    hb_state_t state, state_nxt;

    logic [CNT_W-1:0]          cnt;
    logic signed [DIN_W-1:0]   x [10];
    logic                      accept, drop, mac_en, emit_a, emit_b;
    logic [3:0]                k_sel;
    logic signed [DIN_W-1:0]   tap_a, tap_b;
    logic signed [COEF_W-1:0]  coef_sel;
    logic signed [DOUT_W-1:0]  acc;
    logic signed [PROD_W-1:0]  centre_p0;

    // cnt counts edges since the accepting edge: in MAC it is the pair index,
    // afterwards it times the odd-phase output.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mac_en    = 1'b0;
        emit_a    = 1'b0;
        emit_b    = 1'b0;
        case (state)
            IDLE: begin
                if (nd) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (cnt == CNT_W'(N_PAIRS - 1)) state_nxt = EMIT_A;
            end
            EMIT_A: begin
                emit_a    = 1'b1;
                state_nxt = WAIT_B;
            end
            WAIT_B: begin
                if (cnt == CNT_W'(HALF_PERIOD - 2)) state_nxt = EMIT_B;
            end
            EMIT_B: begin
                emit_b    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        drop = nd && (state != IDLE);
    end

    always_comb begin
        k_sel     = mac_en ? cnt[3:0] : 4'd0;
        tap_a     = x[k_sel];
        tap_b     = x[4'd9 - k_sel];
        coef_sel  = hb_pair_coef(k_sel[2:0]);
        centre_p0 = PROD_W'(x[4]) * PROD_W'(H9);
    end

    hb_serial_mac #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (mac_en),
        .a    (tap_a),
        .b    (tap_b),
        .coef (coef_sel),
        .acc  (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_ph  <= 1'b0;
            ovf      <= 1'b0;
            for (int i = 0; i < 10; i++) x[i] <= '0;
        end else begin
            state    <= state_nxt;
            dout_vld <= 1'b0;
            if (accept) begin
                cnt <= '0;
                for (int i = 9; i > 0; i--) x[i] <= x[i-1];
                x[0] <= din;
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (drop) ovf <= 1'b1;
            if (emit_a) begin
                dout     <= acc;
                dout_ph  <= 1'b0;
                dout_vld <= 1'b1;
            end
            if (emit_b) begin
                dout     <= DOUT_W'(centre_p0);
                dout_ph  <= 1'b1;
                dout_vld <= 1'b1;
            end
        end
    end

endmodule
